// File: rtl/cmp_iter.sv
// Iterative magnitude comparator: walks the operands one CHUNK-bit slice per cycle,
// MSB slice first, stopping at the first slice that differs.
module cmp_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      A,
    input  logic [WIDTH-1:0]                      B,
    input  logic                                  signed_mode,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  GT,
    output logic                                  LT,
    output logic                                  EQ,
    output logic [$clog2(WIDTH/CHUNK):0]          slices
);

    localparam int N  = WIDTH / CHUNK;
    localparam int SW = $clog2(N) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [SW-1:0] N_SW     = SW'(N);
    localparam logic [CHUNK-1:0] SIGN_FLIP = {1'b1, {(CHUNK-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("cmp_iter: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IW-1:0]    r_idx;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;
    logic [SW-1:0]    r_slices;

    logic [WIDTH-1:0] w_shA;
    logic [WIDTH-1:0] w_shB;
    logic [CHUNK-1:0] w_sliceA;
    logic [CHUNK-1:0] w_sliceB;
    logic [SW-1:0]    w_count;

    // Flipping the sign bit of the top slice turns a two's-complement compare
    // into an unsigned one; lower slices are magnitude bits either way.
    always_comb begin
        w_shA    = r_a >> (32'(r_idx) * CHUNK);
        w_shB    = r_b >> (32'(r_idx) * CHUNK);
        w_sliceA = w_shA[CHUNK-1:0];
        w_sliceB = w_shB[CHUNK-1:0];
        if (r_signed && (r_idx == LAST_IDX)) begin
            w_sliceA = w_sliceA ^ SIGN_FLIP;
            w_sliceB = w_sliceB ^ SIGN_FLIP;
        end
        w_count = N_SW - SW'(r_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_slices <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_signed <= signed_mode;
                        r_idx    <= LAST_IDX;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_sliceA != w_sliceB) begin
                        r_gt     <= (w_sliceA > w_sliceB);
                        r_lt     <= (w_sliceA < w_sliceB);
                        r_slices <= w_count;
                        r_state  <= S_DONE;
                    end else if (r_idx == '0) begin
                        r_eq     <= 1'b1;
                        r_slices <= N_SW;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_gt     <= 1'b0;
                        r_lt     <= 1'b0;
                        r_eq     <= 1'b0;
                        r_slices <= '0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign GT        = r_gt;
    assign LT        = r_lt;
    assign EQ        = r_eq;
    assign slices    = r_slices;

endmodule

// File: tb/tb_cmp_iter.sv
// Self-checking bench for cmp_iter (WIDTH=32, CHUNK=8): directed vector table,
// hold/reset sequences, and random compares against an arithmetic model.
module tb_cmp_iter;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        signedMode;
    logic        outValid;
    logic        outReady;
    logic        gt;
    logic        lt;
    logic        eq;
    logic [2:0]  slices;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic        eGt;
        logic        eLt;
        logic        eEq;
        int          eSlices;
    } vector_t;

    vector_t vectors[$];

    cmp_iter #(.WIDTH(32), .CHUNK(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .A           (opA),
        .B           (opB),
        .signed_mode (signedMode),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .GT          (gt),
        .LT          (lt),
        .EQ          (eq),
        .slices      (slices)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: full-width compare plus a count of slices down to the first differing byte.
    function automatic void modelCompare(input logic [31:0] a, input logic [31:0] b, input logic sm,
                                         output logic eGt, output logic eLt, output logic eEq, output int k);
        bit found;
        if (sm) begin
            eGt = $signed(a) > $signed(b);
            eLt = $signed(a) < $signed(b);
        end else begin
            eGt = a > b;
            eLt = a < b;
        end
        eEq   = (a == b);
        k     = 4;
        found = 0;
        for (int i = 3; i >= 0; i--) begin
            if (!found && (a[i*8 +: 8] != b[i*8 +: 8])) begin
                k     = 4 - i;
                found = 1;
            end
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sm,
                                 input logic eGt, input logic eLt, input logic eEq, input int eSlices,
                                 input int hold);
        int n;
        logic [6:0] held;
        @(negedge clk);
        checkOutput("in_ready before accept", 32'(inReady), 32'd1);
        opA        = a;
        opB        = b;
        signedMode = sm;
        inValid    = 1'b1;
        @(posedge clk);
        #1;
        inValid    = 1'b0;
        opA        = $urandom;
        opB        = $urandom;
        signedMode = 1'($urandom);
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (outValid) break;
            checkOutput("results zero while busy", {25'd0, inReady, gt, lt, eq, slices}, 32'd0);
            if (n > 10) begin
                checkOutput("out_valid timeout", 32'(outValid), 32'd1);
                return;
            end
        end
        checkOutput("latency", 32'(n), 32'(eSlices));
        checkOutput("GT", 32'(gt), 32'(eGt));
        checkOutput("LT", 32'(lt), 32'(eLt));
        checkOutput("EQ", 32'(eq), 32'(eEq));
        checkOutput("slices", 32'(slices), 32'(eSlices));
        held = {1'b1, 1'b0, eGt, eLt, eEq, 3'(eSlices)} >> 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold out_valid", 32'(outValid), 32'd1);
            checkOutput("hold in_ready", 32'(inReady), 32'd0);
            checkOutput("hold results", {26'd0, gt, lt, eq, slices}, {26'd0, eGt, eLt, eEq, 3'(eSlices)});
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("handoff out_valid", 32'(outValid), 32'd0);
        checkOutput("handoff in_ready", 32'(inReady), 32'd1);
        checkOutput("handoff results cleared", {26'd0, gt, lt, eq, slices}, 32'd0);
        if (held == 7'h7f) $display("[TB] note: unreachable");
    endtask

    initial begin
        logic        mGt, mLt, mEq;
        int          mK;
        logic [31:0] ra, rb, mask;
        logic        rsm;

        rst        = 1'b1;
        inValid    = 1'b0;
        opA        = '0;
        opB        = '0;
        signedMode = 1'b0;
        outReady   = 1'b0;

        vectors.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vectors.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1});
        vectors.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1});
        vectors.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vectors.push_back('{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 4});
        vectors.push_back('{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, 4});
        vectors.push_back('{32'h1234_5679, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 4});
        vectors.push_back('{32'h1233_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 2});
        vectors.push_back('{32'hFFFF_FF00, 32'hFFFF_FF01, 1'b1, 1'b0, 1'b1, 1'b0, 4});
        vectors.push_back('{32'h7F00_0000, 32'h7E00_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1});

        #12;
        checkOutput("reset in_ready", 32'(inReady), 32'd1);
        checkOutput("reset outputs", {27'd0, outValid, gt, lt, eq, slices} >> 0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vectors[i])
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].sm,
                          vectors[i].eGt, vectors[i].eLt, vectors[i].eEq, vectors[i].eSlices, 0);

        // Result held while consumer stalls.
        applyStimulus(32'h1233_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5);

        // Asynchronous reset in the middle of an equal-operand compare.
        @(negedge clk);
        opA        = 32'hA5A5_A5A5;
        opB        = 32'hA5A5_A5A5;
        signedMode = 1'b0;
        inValid    = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("mid-run reset in_ready", 32'(inReady), 32'd1);
        checkOutput("mid-run reset out_valid", 32'(outValid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("aborted compare stays silent", {28'd0, outValid, gt, lt, eq} , 32'd0);
        end
        applyStimulus(32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0);

        // Random compares; difference forced into a random byte so every k is exercised.
        for (int t = 0; t < 60; t++) begin
            ra   = $urandom;
            rsm  = 1'($urandom);
            mask = 32'd0;
            case ($urandom_range(0, 4))
                0: mask = 32'd0;
                1: mask = $urandom & 32'h0000_00FF;
                2: mask = $urandom & 32'h0000_FFFF;
                3: mask = $urandom & 32'h00FF_FFFF;
                default: mask = $urandom;
            endcase
            rb = ra ^ mask;
            modelCompare(ra, rb, rsm, mGt, mLt, mEq, mK);
            applyStimulus(ra, rb, rsm, mGt, mLt, mEq, mK, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
